// File: rtl/multicycle_ctrl_hs.sv
// Multicycle controller FSM for the accumulator CPU with a memory ready handshake,
// a wait-state timeout that traps into an error state, and a HALT opcode.
module multicycle_ctrl_hs #(
   parameter int ACC_SEL_W = 2,
   parameter int ALU_OP_W  = 2,
   parameter int TIMEOUT   = 16,
   parameter int TO_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           ir,
   input  logic [4:0]           di,
   input  logic [2:0]           czn,
   input  logic                 mem_ready,
   output logic                 done,
   output logic                 busy,
   output logic                 err,
   output logic                 mem_req,
   output logic                 pc_inc,
   output logic                 pc_or_tr,
   output logic                 reg_or_mem,
   output logic                 reg_b_or0,
   output logic                 reg_a_or0,
   output logic                 pc_ld,
   output logic                 di_ld,
   output logic                 acc_we,
   output logic                 mem_we,
   output logic                 ir_we,
   output logic                 tr_we,
   output logic                 b_we,
   output logic                 a_we,
   output logic                 alu_res_we,
   output logic                 ld_czn,
   output logic [ALU_OP_W-1:0]  alu_op,
   output logic [ACC_SEL_W-1:0] acc_sel,
   output logic [3:0]           state_o
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_ARM     = 4'd1;
   localparam logic [3:0] S_FETCH   = 4'd2;
   localparam logic [3:0] S_DECODE  = 4'd3;
   localparam logic [3:0] S_FETCH2  = 4'd4;
   localparam logic [3:0] S_LDOPS16 = 4'd5;
   localparam logic [3:0] S_CALC16  = 4'd6;
   localparam logic [3:0] S_WB16    = 4'd7;
   localparam logic [3:0] S_LDACC   = 4'd8;
   localparam logic [3:0] S_CALC    = 4'd9;
   localparam logic [3:0] S_WBACC   = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;
   localparam logic [3:0] S_ERROR   = 4'd12;

   localparam logic [ALU_OP_W-1:0]  ALU_SUB = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0]  ALU_AND = ALU_OP_W'(2);
   localparam logic [ACC_SEL_W-1:0] SEL_DST = ACC_SEL_W'(1);
   localparam logic [ACC_SEL_W-1:0] SEL_SRC = ACC_SEL_W'(2);
   localparam logic [TO_W-1:0]      TO_LIM  = TO_W'(TIMEOUT);
   localparam bit                   TO_EN   = (TIMEOUT != 0);

   logic [3:0]      state;
   logic [3:0]      state_nx;
   logic [TO_W-1:0] wait_cnt;
   logic            is_sta;
   logic            waiting;
   logic            timeout;
   logic            jump_take;
   logic            unused_di;

   // Only di[2:1] (jump condition) steers the controller; other DI bits belong to the datapath.
   assign unused_di = ^{di[4:3], di[0]};

   assign is_sta  = (ir[3:1] == 3'b001);
   assign waiting = (state == S_FETCH) || (state == S_FETCH2) || ((state == S_WB16) && is_sta);
   assign timeout = TO_EN && waiting && (wait_cnt == TO_LIM);

   always_comb begin
      jump_take = 1'b0;
      case (di[2:1])
         2'b00:   jump_take = 1'b1;
         2'b01:   jump_take = czn[2];
         2'b10:   jump_take = czn[1];
         default: jump_take = czn[0];
      endcase
   end

   // NOTE: every output and the next state get a default before the case so no path infers a latch.
   always_comb begin
      state_nx   = state;
      done       = 1'b0;
      err        = 1'b0;
      mem_req    = 1'b0;
      pc_inc     = 1'b0;
      pc_or_tr   = 1'b0;
      reg_or_mem = 1'b0;
      reg_b_or0  = 1'b0;
      reg_a_or0  = 1'b0;
      pc_ld      = 1'b0;
      di_ld      = 1'b0;
      acc_we     = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      tr_we      = 1'b0;
      b_we       = 1'b0;
      a_we       = 1'b0;
      alu_res_we = 1'b0;
      ld_czn     = 1'b0;
      alu_op     = '0;
      acc_sel    = '0;

      case (state)
         S_IDLE: begin
            done = 1'b1;
            if (start) state_nx = S_ARM;
         end
         S_ARM: begin
            if (!start) state_nx = S_FETCH;
         end
         S_FETCH: begin
            if (timeout) begin
               state_nx = S_ERROR;
            end else begin
               mem_req  = 1'b1;
               pc_or_tr = 1'b1;
               if (mem_ready) begin
                  ir_we    = 1'b1;
                  pc_inc   = 1'b1;
                  state_nx = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            if (!ir[3] || (ir[3:1] == 3'b110)) begin
               state_nx = S_FETCH2;
            end else if (ir == 4'b1110) begin
               di_ld    = 1'b1;
               state_nx = S_FETCH;
            end else if (ir == 4'b1111) begin
               state_nx = S_IDLE;
            end else begin
               acc_sel    = SEL_DST;
               reg_or_mem = 1'b1;
               b_we       = 1'b1;
               state_nx   = S_LDACC;
            end
         end
         S_FETCH2: begin
            if (timeout) begin
               state_nx = S_ERROR;
            end else begin
               mem_req  = 1'b1;
               pc_or_tr = 1'b1;
               if (mem_ready) begin
                  tr_we    = 1'b1;
                  pc_inc   = 1'b1;
                  state_nx = (ir[3:1] == 3'b110) ? S_JUMP : S_LDOPS16;
               end
            end
         end
         S_LDOPS16: begin
            a_we     = 1'b1;
            b_we     = 1'b1;
            acc_sel  = SEL_DST;
            state_nx = S_CALC16;
         end
         S_CALC16: begin
            alu_res_we = 1'b1;
            case (ir[3:1])
               3'b000: begin
                  ld_czn    = 1'b1;
                  reg_a_or0 = 1'b1;
               end
               3'b001: reg_b_or0 = 1'b1;
               3'b010: ld_czn    = 1'b1;
               3'b011: begin
                  ld_czn = 1'b1;
                  alu_op = ALU_SUB;
               end
               default: ;
            endcase
            state_nx = S_WB16;
         end
         S_WB16: begin
            if (!is_sta) begin
               acc_we   = 1'b1;
               state_nx = S_FETCH;
            end else if (timeout) begin
               state_nx = S_ERROR;
            end else begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  mem_we   = 1'b1;
                  state_nx = S_FETCH;
               end
            end
         end
         S_LDACC: begin
            acc_sel  = SEL_SRC;
            a_we     = 1'b1;
            state_nx = S_CALC;
         end
         S_CALC: begin
            alu_res_we = 1'b1;
            case (ir[1:0])
               2'b00: reg_b_or0 = 1'b1;
               2'b01: ld_czn    = 1'b1;
               2'b10: begin
                  ld_czn = 1'b1;
                  alu_op = ALU_SUB;
               end
               default: begin
                  ld_czn = 1'b1;
                  alu_op = ALU_AND;
               end
            endcase
            state_nx = S_WBACC;
         end
         S_WBACC: begin
            acc_sel  = SEL_DST;
            acc_we   = 1'b1;
            state_nx = S_FETCH;
         end
         S_JUMP: begin
            pc_ld    = jump_take;
            state_nx = S_FETCH;
         end
         S_ERROR: begin
            err = 1'b1;
            if (start) state_nx = S_ARM;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy    = (state >= S_FETCH) && (state <= S_JUMP);
   assign state_o = state;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state <= state_nx;
         // The counter only runs across consecutive not-ready cycles in one waiting state.
         if ((state_nx != state) || mem_ready || !waiting) begin
            wait_cnt <= '0;
         end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle output
// sequence from opcode, wait counts and flags, then compared against the controller.
module tb_multicycle_ctrl_hs;

   typedef struct packed {
      logic       done;
      logic       busy;
      logic       err;
      logic       mem_req;
      logic       pc_inc;
      logic       pc_or_tr;
      logic       reg_or_mem;
      logic       reg_b_or0;
      logic       reg_a_or0;
      logic       pc_ld;
      logic       di_ld;
      logic       acc_we;
      logic       mem_we;
      logic       ir_we;
      logic       tr_we;
      logic       b_we;
      logic       a_we;
      logic       alu_res_we;
      logic       ld_czn;
      logic [1:0] alu_op;
      logic [1:0] acc_sel;
      logic [3:0] state_o;
   } outs_t;

   localparam logic [3:0] IDLE = 4'd0, ARM = 4'd1, FETCH = 4'd2, DECODE = 4'd3, FETCH2 = 4'd4,
                          LDOPS16 = 4'd5, CALC16 = 4'd6, WB16 = 4'd7, LDACC = 4'd8, CALC = 4'd9,
                          WBACC = 4'd10, JUMP = 4'd11, ERROR = 4'd12;

   logic       clk = 1'b0;
   logic       rst, start, mem_ready;
   logic [3:0] ir;
   logic [4:0] di;
   logic [2:0] czn;
   logic       done, busy, err, mem_req, pc_inc, pc_or_tr, reg_or_mem, reg_b_or0, reg_a_or0;
   logic       pc_ld, di_ld, acc_we, mem_we, ir_we, tr_we, b_we, a_we, alu_res_we, ld_czn;
   logic [1:0] alu_op, acc_sel;
   logic [3:0] state_o;
   outs_t      got;

   logic [3:0] nx_ir  = '0;
   logic [4:0] nx_di  = '0;
   logic [2:0] nx_czn = '0;
   int         checks = 0;
   int         passed = 0;
   int         fails  = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_hs #(.ACC_SEL_W(2), .ALU_OP_W(2), .TIMEOUT(4), .TO_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .ir(ir), .di(di), .czn(czn), .mem_ready(mem_ready),
      .done(done), .busy(busy), .err(err), .mem_req(mem_req), .pc_inc(pc_inc), .pc_or_tr(pc_or_tr),
      .reg_or_mem(reg_or_mem), .reg_b_or0(reg_b_or0), .reg_a_or0(reg_a_or0), .pc_ld(pc_ld),
      .di_ld(di_ld), .acc_we(acc_we), .mem_we(mem_we), .ir_we(ir_we), .tr_we(tr_we), .b_we(b_we),
      .a_we(a_we), .alu_res_we(alu_res_we), .ld_czn(ld_czn), .alu_op(alu_op), .acc_sel(acc_sel),
      .state_o(state_o)
   );

   assign got = {done, busy, err, mem_req, pc_inc, pc_or_tr, reg_or_mem, reg_b_or0, reg_a_or0,
                 pc_ld, di_ld, acc_we, mem_we, ir_we, tr_we, b_we, a_we, alu_res_we, ld_czn,
                 alu_op, acc_sel, state_o};

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   // Status outputs implied by the state alone; strobes are added by the caller.
   function automatic outs_t at(input logic [3:0] s);
      outs_t o;
      o         = '0;
      o.state_o = s;
      o.done    = (s == IDLE);
      o.err     = (s == ERROR);
      o.busy    = !((s == IDLE) || (s == ARM) || (s == ERROR));
      return o;
   endfunction

   function automatic logic taken(input logic [4:0] d, input logic [2:0] f);
      case (d[2:1])
         2'd0:    return 1'b1;
         2'd1:    return f[2];
         2'd2:    return f[1];
         default: return f[0];
      endcase
   endfunction

   task automatic check(input outs_t e, input string tag);
      checks++;
      assert (got === e) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, e);
      end
   endtask

   task automatic step(input logic s, input logic rdy, input outs_t e, input string tag);
      @(negedge clk);
      start     = s;
      mem_ready = rdy;
      ir        = nx_ir;
      di        = nx_di;
      czn       = nx_czn;
      #1 check(e, tag);
      @(posedge clk);
   endtask

   task automatic mem_phase(input int waits, input outs_t base, input outs_t fire, input string tag);
      for (int i = 0; i < waits; i++) step(rb(), 1'b0, base, {tag, "_wait"});
      step(rb(), 1'b1, base | fire, tag);
   endtask

   task automatic restart();
      step(1'b1, rb(), at(IDLE), "idle_start");
      step(1'b0, rb(), at(ARM), "arm_release");
   endtask

   // Drives one instruction starting in FETCH; halted=1 means the controller is left in IDLE.
   task automatic run_instr(input logic [3:0] op, input logic [4:0] d, input logic [2:0] f,
                            input int wf, input int wf2, input int ww, input bit abort,
                            output bit halted);
      outs_t e, fire;
      nx_ir  = op;
      nx_di  = d;
      nx_czn = f;
      halted = 1'b0;
      e = at(FETCH);  e.mem_req = 1'b1;  e.pc_or_tr = 1'b1;
      fire = '0;  fire.ir_we = 1'b1;  fire.pc_inc = 1'b1;
      mem_phase(wf, e, fire, "fetch");
      e = at(DECODE);
      if (op == 4'b1111) begin
         step(rb(), rb(), e, "decode_halt");
         halted = 1'b1;
         return;
      end
      if (op == 4'b1110) begin
         e.di_ld = 1'b1;
         step(rb(), rb(), e, "decode_nop");
         return;
      end
      if (op[3:2] == 2'b10) begin
         e.acc_sel = 2'd1;  e.reg_or_mem = 1'b1;  e.b_we = 1'b1;
         step(rb(), rb(), e, "decode_reg");
         e = at(LDACC);  e.acc_sel = 2'd2;  e.a_we = 1'b1;
         step(rb(), rb(), e, "ldacc");
         e = at(CALC);  e.alu_res_we = 1'b1;
         case (op[1:0])
            2'd0: e.reg_b_or0 = 1'b1;
            2'd1: e.ld_czn = 1'b1;
            2'd2: begin e.ld_czn = 1'b1; e.alu_op = 2'd1; end
            default: begin e.ld_czn = 1'b1; e.alu_op = 2'd2; end
         endcase
         step(rb(), rb(), e, "calc");
         e = at(WBACC);  e.acc_sel = 2'd1;  e.acc_we = 1'b1;
         step(rb(), rb(), e, "wbacc");
         return;
      end
      step(rb(), rb(), e, "decode_mem");
      e = at(FETCH2);  e.mem_req = 1'b1;  e.pc_or_tr = 1'b1;
      fire = '0;  fire.tr_we = 1'b1;  fire.pc_inc = 1'b1;
      mem_phase(wf2, e, fire, "fetch2");
      if (op[3:1] == 3'b110) begin
         e = at(JUMP);  e.pc_ld = taken(d, f);
         step(rb(), rb(), e, "jump");
         return;
      end
      e = at(LDOPS16);  e.a_we = 1'b1;  e.b_we = 1'b1;  e.acc_sel = 2'd1;
      step(rb(), rb(), e, "ldops16");
      if (abort) begin
         @(negedge clk);
         start = 1'b0;  mem_ready = rb();  rst = 1'b1;
         #1 check(at(IDLE), "rst_mid_calc16");
         @(negedge clk);
         rst = 1'b0;
         #1 check(at(IDLE), "rst_release");
         @(posedge clk);
         halted = 1'b1;
         return;
      end
      e = at(CALC16);  e.alu_res_we = 1'b1;
      case (op[2:1])
         2'd0: begin e.ld_czn = 1'b1; e.reg_a_or0 = 1'b1; end
         2'd1: e.reg_b_or0 = 1'b1;
         2'd2: e.ld_czn = 1'b1;
         default: begin e.ld_czn = 1'b1; e.alu_op = 2'd1; end
      endcase
      step(rb(), rb(), e, "calc16");
      if (op[3:1] == 3'b001) begin
         e = at(WB16);  e.mem_req = 1'b1;
         fire = '0;  fire.mem_we = 1'b1;
         mem_phase(ww, e, fire, "wb16_sta");
      end else begin
         e = at(WB16);  e.acc_we = 1'b1;
         step(rb(), rb(), e, "wb16");
      end
   endtask

   initial begin
      bit         h;
      outs_t      e;
      logic [3:0] op;
      rst = 1'b0;  start = 1'b0;  mem_ready = 1'b0;  ir = '0;  di = '0;  czn = '0;
      #1 rst = 1'b1;
      #1 check(at(IDLE), "reset");
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, rb(), at(IDLE), "idle");
      step(1'b1, rb(), at(IDLE), "idle_start");
      step(1'b1, rb(), at(ARM), "arm_hold");
      step(1'b0, rb(), at(ARM), "arm_release");

      run_instr(4'b0000, 5'($urandom), 3'($urandom), 2, 2, 0, 1'b0, h);   // LDA with waits
      run_instr(4'b0010, 5'($urandom), 3'($urandom), 0, 0, 3, 1'b0, h);   // STA, waits in WB16
      run_instr(4'b1010, 5'($urandom), 3'($urandom), 0, 0, 0, 1'b0, h);   // reg SUB
      run_instr(4'b1011, 5'($urandom), 3'($urandom), 1, 0, 0, 1'b0, h);   // reg AND
      run_instr(4'b1100, 5'b00100, 3'b000, 0, 1, 0, 1'b0, h);             // JZ not taken
      run_instr(4'b1100, 5'b00100, 3'b010, 0, 0, 0, 1'b0, h);             // JZ taken

      for (int n = 0; n < 40; n++) begin
         op = 4'($urandom);
         run_instr(op, 5'($urandom), 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'b0, h);
         if (h) restart();
      end

      // Timeout: four not-ready cycles in FETCH, then a strobe-free timeout cycle, then ERROR.
      e = at(FETCH);  e.mem_req = 1'b1;  e.pc_or_tr = 1'b1;
      for (int i = 0; i < 4; i++) step(rb(), 1'b0, e, "to_wait");
      step(1'b0, 1'b1, at(FETCH), "to_cycle");
      step(1'b0, rb(), at(ERROR), "error_hold");
      step(1'b1, rb(), at(ERROR), "error_start");
      step(1'b0, rb(), at(ARM), "arm_after_err");

      run_instr(4'b1111, 5'($urandom), 3'($urandom), 0, 0, 0, 1'b0, h);   // HALT
      step(1'b0, rb(), at(IDLE), "halt_idle");
      restart();

      run_instr(4'b0100, 5'($urandom), 3'($urandom), 0, 0, 0, 1'b1, h);   // rst in CALC16
      step(1'b0, rb(), at(IDLE), "post_rst_idle");
      restart();
      run_instr(4'b0110, 5'($urandom), 3'($urandom), 1, 1, 0, 1'b0, h);   // SUB after reset

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
